// File: rtl/cpu_stage_sequencer.sv
// Instruction stage sequencer for the SM5a/SM510 core: fetch, operand fetch,
// execute/commit strobes, skip chaining and halt/wake.
module cpu_stage_sequencer #(
  parameter int          ROM_LATENCY = 1,
  parameter int unsigned SM510_ID    = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_en,
  input  logic [3:0] cpu_id,
  input  logic [7:0] rom_data,
  input  logic       skip_req,
  input  logic       skip_lax_req,
  input  logic       halt_req,
  input  logic       wake,
  output logic [2:0] stage,
  output logic [7:0] opcode,
  output logic [7:0] last_opcode,
  output logic [7:0] operand,
  output logic       pc_inc,
  output logic       exec_en,
  output logic       commit_en,
  output logic       halted,
  output logic       wake_pulse
);

  // state         | meaning
  // LOAD_PC       | present PC to ROM, load latency timer
  // FETCH         | wait for ROM data, capture opcode
  // LOAD_OPERAND  | present PC for second byte
  // FETCH_OPERAND | wait for ROM data, capture operand
  // EXECUTE       | execute strobe unless skipped
  // COMMIT        | register commit, sample skip/halt requests
  // HALT          | idle until wake
  typedef enum logic [2:0] {
    LOAD_PC       = 3'd0,
    FETCH         = 3'd1,
    LOAD_OPERAND  = 3'd2,
    FETCH_OPERAND = 3'd3,
    EXECUTE       = 3'd4,
    COMMIT        = 3'd5,
    HALT          = 3'd6
  } stage_t;

  localparam logic [1:0] LAT_LOAD = 2'(ROM_LATENCY - 1);

  stage_t     state;
  logic [1:0] lat_cnt;
  logic       skip_pend;
  logic       lax_pend;
  logic       skipped;
  logic       two_byte;
  logic       skip_now;
  logic       rom_done;

  assign two_byte = (cpu_id == 4'(SM510_ID)) && (rom_data[7:4] == 4'h7);
  assign skip_now = skip_pend || (lax_pend && (opcode[7:4] == 4'h2));
  assign rom_done = (lat_cnt == 2'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= LOAD_PC;
      lat_cnt     <= 2'd0;
      opcode      <= 8'h00;
      last_opcode <= 8'h00;
      operand     <= 8'h00;
      skip_pend   <= 1'b0;
      lax_pend    <= 1'b0;
      skipped     <= 1'b0;
      halted      <= 1'b0;
    end else if (clk_en) begin
      case (state)
        LOAD_PC: begin
          lat_cnt <= LAT_LOAD;
          state   <= FETCH;
        end
        FETCH: begin
          if (rom_done) begin
            opcode      <= rom_data;
            last_opcode <= opcode;
            state       <= two_byte ? LOAD_OPERAND : EXECUTE;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        LOAD_OPERAND: begin
          lat_cnt <= LAT_LOAD;
          state   <= FETCH_OPERAND;
        end
        FETCH_OPERAND: begin
          if (rom_done) begin
            operand <= rom_data;
            state   <= EXECUTE;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        EXECUTE: begin
          skipped   <= skip_now;
          skip_pend <= 1'b0;
          lax_pend  <= 1'b0;
          state     <= COMMIT;
        end
        COMMIT: begin
          // A skipped instruction must not re-arm a skip or halt the core.
          if (!skipped) begin
            skip_pend <= skip_req;
            lax_pend  <= skip_lax_req;
          end
          if (halt_req && !skipped) begin
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            state <= LOAD_PC;
          end
        end
        HALT: begin
          if (wake) begin
            halted <= 1'b0;
            state  <= LOAD_PC;
          end
        end
        default: state <= LOAD_PC;
      endcase
    end
  end

  // Strobes are decoded from registered state so they land in the tick they act on.
  assign pc_inc     = clk_en && ((state == FETCH) || (state == FETCH_OPERAND)) && rom_done;
  assign exec_en    = clk_en && (state == EXECUTE) && !skip_now;
  assign commit_en  = clk_en && (state == COMMIT);
  assign wake_pulse = clk_en && (state == HALT) && wake;
  assign stage      = state;

endmodule
